// File: rtl/inst_encoder.sv
// Packs decoded RV32I instruction fields into 32-bit words and streams them into instruction memory.
// Optional macro ENC_ILLEGAL_CHECK_EN rejects unused classes and odd branch offsets with an err pulse.
module inst_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         finish,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_class,
    input  logic [2:0]                   req_funct3,
    input  logic [6:0]                   req_funct7,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_rs1,
    input  logic [4:0]                   req_rs2,
    input  logic [12:0]                  req_imm,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_waddr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         done,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_IALU   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic accept;
    logic illegal;
    logic write_ok;
    logic last_word;

    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] word;
        case (cls)
            CLS_R:      word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            CLS_LOAD:   word = {imm[11:0], rs1, f3, rd, 7'b0000011};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            CLS_IALU:   word = {imm[11:0], rs1, f3, rd, 7'b0010011};
            default:    word = 32'h0000_0013;
        endcase
        return word;
    endfunction

    assign req_ready = (state == RUN);
    assign done      = (state == FULL) || (state == DONE);
    assign accept    = req_valid && req_ready;
    assign last_word = (word_count == CW'(DEPTH - 1));

`ifdef ENC_ILLEGAL_CHECK_EN
    logic err_q;

    assign illegal = (req_class > CLS_IALU) || ((req_class == CLS_BRANCH) && req_imm[0]);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && illegal;
        end
    end
`else
    // Branch offsets are always even, so imm[0] carries no encoding information here.
    logic unused_imm_lsb;

    assign unused_imm_lsb = req_imm[0];
    assign illegal        = 1'b0;
    assign err            = 1'b0;
`endif

    assign write_ok = accept && !illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;

            // Address and data only move on a real write; they hold otherwise.
            if (write_ok) begin
                imem_we    <= 1'b1;
                imem_waddr <= ADDR_W'(word_count) << 2;
                imem_wdata <= encode(req_class, req_funct3, req_funct7,
                                     req_rd, req_rs1, req_rs2, req_imm);
                word_count <= word_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        word_count <= '0;
                    end
                end
                RUN: begin
                    if (write_ok && last_word) begin
                        state <= FULL;
                    end else if (finish) begin
                        state <= DONE;
                    end
                end
                FULL, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        word_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
